// File: rtl/ad7705_slave.sv
// Behavioural AD7705 SPI slave: decodes comms bytes, holds setup/clock registers,
// serves status and 16-bit data reads, and resyncs on 32 consecutive MOSI ones.
module ad7705_slave #(
    parameter logic       DRDY_READY_LEVEL = 1'b1,
    parameter logic [7:0] SETUP_RST        = 8'h01,
    parameter logic [7:0] CLOCK_RST        = 8'h05
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        adc_reset,
    input  logic        SCK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [15:0] sample,
    input  logic        sample_valid,
    output logic        drdy,
    output logic [7:0]  setup_reg,
    output logic [7:0]  clock_reg,
    output logic        data_read
);

    typedef enum logic [1:0] {COMM, WRITE, READ} state_t;

    state_t      state, state_d;
    logic        sck_s1, sck_s2, sck_d, mosi_s1, mosi_s2;
    logic [6:0]  shift_in;
    logic [3:0]  bit_cnt;
    logic [4:0]  ones_cnt;
    logic [2:0]  rs_q;
    logic [15:0] shift_out, data_reg, out_word;
    logic        sv_during;

    logic        rise, fall, bit_in, resync, byte_done;
    logic        comm_accept, enter_read, wr_setup, wr_clock, data_done;
    logic [7:0]  byte_in;
    logic [3:0]  last_bit;

    assign rise     = sck_s2 & ~sck_d;
    assign fall     = ~sck_s2 & sck_d;
    assign bit_in   = mosi_s2;
    assign byte_in  = {shift_in, bit_in};
    assign resync   = rise && bit_in && (ones_cnt == 5'd31);
    assign last_bit = (state == READ && rs_q == 3'd3) ? 4'd15 : 4'd7;
    assign byte_done = rise && !resync && (bit_cnt == last_bit);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state;
        comm_accept = 1'b0;
        enter_read  = 1'b0;
        wr_setup    = 1'b0;
        wr_clock    = 1'b0;
        data_done   = 1'b0;
        case (state)
            COMM: if (byte_done && !byte_in[7]) begin
                comm_accept = 1'b1;
                enter_read  = byte_in[3];
                state_d     = byte_in[3] ? READ : WRITE;
            end
            WRITE: if (byte_done) begin
                wr_setup = (rs_q == 3'd1);
                wr_clock = (rs_q == 3'd2);
                state_d  = COMM;
            end
            READ: if (byte_done) begin
                data_done = (rs_q == 3'd3);
                state_d   = COMM;
            end
            default: state_d = COMM;
        endcase
        if (resync) state_d = COMM;
    end

    // Read word is left-justified so 8-bit reads use the top byte.
    always_comb begin
        out_word = 16'h0000;
        case (byte_in[6:4])
            3'd0: out_word = {(drdy ? DRDY_READY_LEVEL : ~DRDY_READY_LEVEL), byte_in[6:0], 8'h00};
            3'd1: out_word = {setup_reg, 8'h00};
            3'd2: out_word = {clock_reg, 8'h00};
            3'd3: out_word = data_reg;
            default: out_word = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          state <= COMM;
        else if (!adc_reset) state <= COMM;
        else                 state <= state_d;
    end

    // NOTE: state uses non-blocking assignments only; the soft reset mirrors the async one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {sck_s1, sck_s2, sck_d} <= 3'b111;
            {mosi_s1, mosi_s2}      <= 2'b00;
            shift_in  <= '0;
            bit_cnt   <= '0;
            ones_cnt  <= '0;
            rs_q      <= '0;
            shift_out <= '0;
            data_reg  <= '0;
            sv_during <= 1'b0;
            MISO      <= 1'b1;
            drdy      <= 1'b0;
            data_read <= 1'b0;
            setup_reg <= SETUP_RST;
            clock_reg <= CLOCK_RST;
        end else if (!adc_reset) begin
            {sck_s1, sck_s2, sck_d} <= 3'b111;
            {mosi_s1, mosi_s2}      <= 2'b00;
            shift_in  <= '0;
            bit_cnt   <= '0;
            ones_cnt  <= '0;
            rs_q      <= '0;
            shift_out <= '0;
            data_reg  <= '0;
            sv_during <= 1'b0;
            MISO      <= 1'b1;
            drdy      <= 1'b0;
            data_read <= 1'b0;
            setup_reg <= SETUP_RST;
            clock_reg <= CLOCK_RST;
        end else begin
            sck_s1  <= SCK;
            sck_s2  <= sck_s1;
            sck_d   <= sck_s2;
            mosi_s1 <= MOSI;
            mosi_s2 <= mosi_s1;

            if (rise) begin
                shift_in <= byte_in[6:0];
                ones_cnt <= (!bit_in || resync) ? 5'd0 : ones_cnt + 5'd1;
                bit_cnt  <= (byte_done || resync) ? 4'd0 : bit_cnt + 4'd1;
            end

            if (comm_accept) rs_q <= byte_in[6:4];
            if (wr_setup)    setup_reg <= byte_in;
            if (wr_clock)    clock_reg <= byte_in;
            if (sample_valid) data_reg <= sample;

            // A new sample outranks both clearing sources in the same cycle.
            if (sample_valid)                  drdy <= 1'b1;
            else if (data_done && !sv_during)  drdy <= 1'b0;
            else if (wr_setup)                 drdy <= 1'b0;

            if (enter_read)                          sv_during <= 1'b0;
            else if (state == READ && sample_valid)  sv_during <= 1'b1;

            data_read <= data_done;

            // First falling edge re-presents the MSB; later ones advance the word.
            if (state_d == READ) begin
                if (enter_read) begin
                    shift_out <= out_word;
                    MISO      <= out_word[15];
                end else if (fall) begin
                    MISO      <= shift_out[15];
                    shift_out <= {shift_out[14:0], 1'b0};
                end
            end else begin
                MISO <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ad7705_slave.sv
// Directed bench for ad7705_slave: acts as a mode-3 SPI master and checks
// register writes, status/data reads, drdy rules, resync and both resets.
module tb_ad7705_slave;

    logic        clk = 1'b0;
    logic        reset, adc_reset, SCK, MOSI, MISO;
    logic [15:0] sample;
    logic        sample_valid, drdy, data_read;
    logic [7:0]  setup_reg, clock_reg;

    int n_cmp = 0;
    int n_err = 0;
    int dr_cnt = 0;

    ad7705_slave dut (
        .clk(clk), .reset(reset), .adc_reset(adc_reset),
        .SCK(SCK), .MOSI(MOSI), .MISO(MISO),
        .sample(sample), .sample_valid(sample_valid),
        .drdy(drdy), .setup_reg(setup_reg), .clock_reg(clock_reg),
        .data_read(data_read)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (data_read) dr_cnt <= dr_cnt + 1;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One SCK period: 8 clk low, 8 clk high; MISO captured just before the rising edge.
    task automatic spi_bit(input logic b, output logic r);
        SCK = 1'b0; MOSI = b;
        #80;
        r = MISO;
        SCK = 1'b1;
        #80;
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic pulse_sample(input logic [15:0] v);
        @(negedge clk);
        sample = v; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic settle;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [7:0] rx, rx2;
        logic       r;
        int         dr0;

        reset = 1'b0; adc_reset = 1'b1; SCK = 1'b1; MOSI = 1'b0;
        sample = 16'h0; sample_valid = 1'b0;
        #20 reset = 1'b1;
        settle();
        check("rst_miso", {15'd0, MISO}, 16'h1);
        check("rst_drdy", {15'd0, drdy}, 16'h0);
        check("rst_setup", {8'd0, setup_reg}, 16'h01);
        check("rst_clock", {8'd0, clock_reg}, 16'h05);
        check("rst_data_read", {15'd0, data_read}, 16'h0);

        // configure sequence
        xfer(8'd32, rx); xfer(8'd12, rx); xfer(8'd16, rx); xfer(8'd68, rx);
        settle();
        check("cfg_clock", {8'd0, clock_reg}, 16'h0C);
        check("cfg_setup", {8'd0, setup_reg}, 16'h44);
        check("cfg_drdy", {15'd0, drdy}, 16'h0);

        xfer(8'h08, rx); xfer(8'h00, rx);
        check("status_not_ready", {8'd0, rx}, 16'h08);

        pulse_sample(16'hA55A);
        settle();
        check("drdy_set", {15'd0, drdy}, 16'h1);
        xfer(8'h08, rx); xfer(8'h00, rx);
        check("status_ready", {8'd0, rx}, 16'h88);

        // plain 16-bit data read
        dr0 = dr_cnt;
        xfer(8'h38, rx); xfer(8'h00, rx); xfer(8'h00, rx2);
        settle();
        check("data_read_word", {rx, rx2}, 16'hA55A);
        check("data_read_pulses", 16'(dr_cnt - dr0), 16'd1);
        check("drdy_after_read", {15'd0, drdy}, 16'h0);

        // sample arrives during the 9th bit of a data read
        pulse_sample(16'hA55A);
        dr0 = dr_cnt;
        xfer(8'h38, rx); xfer(8'h00, rx);
        SCK = 1'b0; MOSI = 1'b0;
        #20;
        sample = 16'h1234; sample_valid = 1'b1;
        #10 sample_valid = 1'b0;
        #50;
        rx2[7] = MISO;
        SCK = 1'b1;
        #80;
        for (int i = 6; i >= 0; i--) begin
            spi_bit(1'b0, r);
            rx2[i] = r;
        end
        settle();
        check("midread_hi", {8'd0, rx}, 16'hA5);
        check("midread_lo", {8'd0, rx2}, 16'h5A);
        check("midread_drdy_kept", {15'd0, drdy}, 16'h1);
        check("midread_pulse", 16'(dr_cnt - dr0), 16'd1);
        xfer(8'h38, rx); xfer(8'h00, rx); xfer(8'h00, rx2);
        settle();
        check("next_data_word", {rx, rx2}, 16'h1234);
        check("next_data_drdy", {15'd0, drdy}, 16'h0);

        // partial byte, then 32 ones, then a comms byte
        spi_bit(1'b1, r); spi_bit(1'b1, r); spi_bit(1'b0, r);
        for (int i = 0; i < 32; i++) spi_bit(1'b1, r);
        xfer(8'h08, rx); xfer(8'h00, rx);
        settle();
        check("resync_status", {8'd0, rx}, 16'h08);
        check("resync_setup", {8'd0, setup_reg}, 16'h44);
        check("resync_clock", {8'd0, clock_reg}, 16'h0C);

        // async reset in the middle of a data read
        pulse_sample(16'hBEEF);
        xfer(8'h38, rx);
        for (int i = 0; i < 4; i++) spi_bit(1'b0, r);
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("areset_miso", {15'd0, MISO}, 16'h1);
        check("areset_drdy", {15'd0, drdy}, 16'h0);
        check("areset_setup", {8'd0, setup_reg}, 16'h01);
        check("areset_clock", {8'd0, clock_reg}, 16'h05);
        @(negedge clk);
        reset = 1'b1;
        settle();
        xfer(8'h08, rx); xfer(8'h00, rx);
        check("areset_comm_state", {8'd0, rx}, 16'h08);

        // setup write clears drdy, then soft reset mid-read
        xfer(8'h10, rx); xfer(8'h44, rx);
        settle();
        check("setup_write", {8'd0, setup_reg}, 16'h44);
        pulse_sample(16'h0F0F);
        settle();
        check("drdy_before_setup", {15'd0, drdy}, 16'h1);
        xfer(8'h10, rx); xfer(8'h44, rx);
        settle();
        check("setup_clears_drdy", {15'd0, drdy}, 16'h0);
        pulse_sample(16'h0F0F);
        xfer(8'h38, rx);
        for (int i = 0; i < 4; i++) spi_bit(1'b0, r);
        @(negedge clk);
        adc_reset = 1'b0;
        repeat (2) @(negedge clk);
        adc_reset = 1'b1;
        check("sreset_miso", {15'd0, MISO}, 16'h1);
        check("sreset_drdy", {15'd0, drdy}, 16'h0);
        check("sreset_setup", {8'd0, setup_reg}, 16'h01);
        check("sreset_clock", {8'd0, clock_reg}, 16'h05);
        settle();
        xfer(8'h08, rx); xfer(8'h00, rx);
        check("sreset_comm_state", {8'd0, rx}, 16'h08);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
